// File: rtl/mips_pkg.sv
// Shared sizing constants for the MIPS32 decode-stage register file.
// Imported by the register file top and the sign extender.
package mips_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int IMM_W      = 16;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/mips_regfile_sext_sign_extend.sv
// Combinational 16-to-32-bit sign extender for the instruction immediate.
// Ports: imm_in (raw inst[15:0]) -> imm_out (sign-extended XLEN value).
module sign_extend
    import mips_pkg::*;
(
    input  logic [IMM_W-1:0] imm_in,
    output logic [XLEN-1:0]  imm_out
);

    assign imm_out = {{(XLEN-IMM_W){imm_in[IMM_W-1]}}, imm_in};

endmodule

// File: rtl/mips_regfile_sext.sv
// Decode-stage 32x32 register file (2 comb reads, 1 sync write, write-through
// bypass), "magic" completion flag and immediate sign extender.
// Ports: clk, rst (sync, active-high); read_addr_1/2 -> data_1/2;
// write_addr/write_data/write_enabled; magic; imm_in -> imm_out.
module mips_regfile_sext
    import mips_pkg::*;
#(
    parameter logic [REG_ADDR_W-1:0] MAGIC_REG   = 5'd2,
    parameter logic [XLEN-1:0]       MAGIC_VALUE = 32'h0000_000A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] read_addr_1,
    input  logic [REG_ADDR_W-1:0] read_addr_2,
    input  logic [REG_ADDR_W-1:0] write_addr,
    input  logic [XLEN-1:0]       write_data,
    input  logic                  write_enabled,
    output logic [XLEN-1:0]       data_1,
    output logic [XLEN-1:0]       data_2,
    output logic                  magic,
    input  logic [IMM_W-1:0]      imm_in,
    output logic [XLEN-1:0]       imm_out
);

    logic [XLEN-1:0] regs_q [REG_COUNT];
    logic            wr_valid;

    // r0 is never written, so a write aimed there is simply dropped.
    assign wr_valid = write_enabled && (write_addr != ZERO_REG);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_valid) begin
            regs_q[write_addr] <= write_data;
        end
    end

    // Same-cycle writeback is forwarded to decode; during reset the
    // forwarded value would be discarded, so the read reports zero.
    always_comb begin
        data_1 = regs_q[read_addr_1];
        if (read_addr_1 == ZERO_REG) begin
            data_1 = '0;
        end else if (wr_valid && (write_addr == read_addr_1)) begin
            data_1 = rst ? '0 : write_data;
        end
    end

    always_comb begin
        data_2 = regs_q[read_addr_2];
        if (read_addr_2 == ZERO_REG) begin
            data_2 = '0;
        end else if (wr_valid && (write_addr == read_addr_2)) begin
            data_2 = rst ? '0 : write_data;
        end
    end

    // Stored state only: the flag rises the cycle after the write edge.
    assign magic = (regs_q[MAGIC_REG] == MAGIC_VALUE);

    sign_extend u_sext (
        .imm_in  (imm_in),
        .imm_out (imm_out)
    );

endmodule

// File: tb/tb_mips_regfile_sext.sv
// Self-checking bench for mips_regfile_sext: directed steps plus random
// traffic compared against an array model of the register file.
module tb_mips_regfile_sext;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  read_addr_1 = '0;
    logic [4:0]  read_addr_2 = '0;
    logic [4:0]  write_addr = '0;
    logic [31:0] write_data = '0;
    logic        write_enabled = 1'b0;
    logic [31:0] data_1;
    logic [31:0] data_2;
    logic        magic;
    logic [15:0] imm_in = '0;
    logic [31:0] imm_out;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] model [32];

    mips_regfile_sext dut (
        .clk           (clk),
        .rst           (rst),
        .read_addr_1   (read_addr_1),
        .read_addr_2   (read_addr_2),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .write_enabled (write_enabled),
        .data_1        (data_1),
        .data_2        (data_2),
        .magic         (magic),
        .imm_in        (imm_in),
        .imm_out       (imm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (write_enabled && write_addr != 0 && write_addr == a)
            return rst ? 32'h0 : write_data;
        return model[a];
    endfunction

    function automatic logic [31:0] exp_sext(input logic [15:0] v);
        logic [31:0] r;
        r = {16'h0, v};
        if (v >= 16'h8000) r = r + 32'hFFFF_0000;
        return r;
    endfunction

    // One cycle: drive, check combinational outputs, clock, update model.
    task automatic cyc(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2);
        rst = r;
        write_enabled = we;
        write_addr = wa;
        write_data = wd;
        read_addr_1 = a1;
        read_addr_2 = a2;
        #1;
        chk("rd1", data_1, exp_rd(a1));
        chk("rd2", data_2, exp_rd(a2));
        chk("magic", {31'h0, magic}, {31'h0, model[2] == 32'hA});
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && wa != 0) begin
            model[wa] = wd;
        end
        #1;
        write_enabled = 1'b0;
        rst = 1'b0;
    endtask

    task automatic sext(input logic [15:0] v, input logic [31:0] exp);
        imm_in = v;
        #1;
        chk("sext", imm_out, exp);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load non-zero values, then reset and sweep every index.
        for (int i = 1; i < 32; i++)
            cyc(0, 1, 5'(i), 32'h100 + 32'(i), 0, 0);
        cyc(1, 0, 0, 0, 3, 4);
        chk("rst_magic", {31'h0, magic}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 0, 0, 5'(i), 5'(31 - i));
            chk("rst_sweep", data_1, 32'h0);
        end

        // Write/read.
        cyc(0, 1, 5, 32'hDEAD_BEEF, 0, 0);
        cyc(0, 0, 0, 0, 5, 5);
        chk("r5_p1", data_1, 32'hDEAD_BEEF);
        chk("r5_p2", data_2, 32'hDEAD_BEEF);

        // r0 hard-wired, including same-cycle bypass.
        cyc(0, 1, 0, 32'hFFFF_FFFF, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("r0", data_1, 32'h0);

        // Bypass then reset priority.
        cyc(0, 1, 7, 32'h1, 0, 0);
        write_enabled = 1'b1; write_addr = 7;
        write_data = 32'h1234; read_addr_2 = 7;
        #1;
        chk("bypass", data_2, 32'h1234);
        cyc(0, 1, 7, 32'h1234, 0, 7);
        cyc(0, 0, 0, 0, 7, 7);
        chk("r7_after", data_1, 32'h1234);
        cyc(1, 1, 7, 32'h1234, 0, 7);
        cyc(0, 0, 0, 0, 7, 0);
        chk("r7_rst", data_1, 32'h0);

        // Magic flag.
        cyc(0, 1, 2, 32'h9, 0, 0);
        chk("magic9", {31'h0, magic}, 32'h0);
        cyc(0, 1, 2, 32'hA, 2, 0);
        chk("magicA", {31'h0, magic}, 32'h1);
        cyc(0, 1, 2, 32'hB, 0, 0);
        chk("magicB", {31'h0, magic}, 32'h0);

        // Sign extension.
        sext(16'h7FFF, 32'h0000_7FFF);
        sext(16'h8000, 32'hFFFF_8000);
        sext(16'hFFFF, 32'hFFFF_FFFF);
        sext(16'h0000, 32'h0000_0000);
        for (int i = 0; i < 40; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            sext(v, exp_sext(v));
        end

        // Random traffic, biased toward r2=A and address collisions.
        for (int i = 0; i < 400; i++) begin
            logic [4:0]  wa, a1, a2;
            logic [31:0] wd;
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            wd = ($urandom_range(0, 5) == 0) ? 32'hA : $urandom;
            if ($urandom_range(0, 7) == 0) wa = 5'd2;
            cyc($urandom_range(0, 39) == 0, 1'($urandom), wa, wd, a1, a2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
